// File: rtl/inst_issue.sv
// inst_issue: replays a loaded instruction program to a PE column.
// It waits for every write-back to return before it reports completion.
module inst_issue #(
  parameter int INST_WIDTH = 64,
  parameter int DEPTH      = 16,
  parameter int PTR_W      = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_v,
  input  logic [INST_WIDTH-1:0] ld_inst,
  input  logic                  clr,
  input  logic                  start,
  input  logic [CNT_W-1:0]      passes,
  input  logic                  stall,
  input  logic                  wb_v,
  output logic                  inst_v,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  busy,
  output logic                  done,
  output logic [PTR_W:0]        prog_len,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t r_state, w_nxt;
  logic [INST_WIDTH-1:0] r_mem [DEPTH];
  logic [INST_WIDTH-1:0] r_inst, w_cur;
  logic [PTR_W-1:0] r_rd_ptr, w_rd_nxt;
  logic [PTR_W:0] r_len;
  logic [CNT_W-1:0] r_pass, w_pass_cur, w_pass_nxt, r_pend, w_pend_nxt;
  logic r_inst_v, r_busy, r_done, r_err;
  logic w_empty, w_go, w_fire, w_last, w_inc, w_ovf, w_unf, w_ld_ok, w_ld_err;
  assign w_empty    = r_len == '0 || passes == '0;
  assign w_go       = r_state == IDLE && start && !w_empty;
  assign w_fire     = (w_go || r_state == ISSUE) && !stall;
  assign w_cur      = r_mem[r_rd_ptr];
  assign w_last     = {1'b0, r_rd_ptr} == r_len - 1'b1;
  assign w_pass_cur = w_go ? passes : r_pass;
  assign w_inc      = w_fire && w_cur[INST_WIDTH-1];
  assign w_ovf      = w_inc && !wb_v && &r_pend;
  assign w_unf      = wb_v && !w_inc && r_pend == '0;
  assign w_pend_nxt = (w_inc && !wb_v && !w_ovf) ? r_pend + 1'b1 :
                      (wb_v && !w_inc && !w_unf) ? r_pend - 1'b1 : r_pend;
  // DEPTH is a power of two, so the top bit of the length marks a full buffer
  assign w_ld_ok    = r_state == IDLE && ld_v && !clr && !r_len[PTR_W];
  assign w_ld_err   = r_state == IDLE && ld_v && !clr && r_len[PTR_W];
  always_comb begin
    w_nxt      = r_state;
    w_rd_nxt   = r_rd_ptr;
    w_pass_nxt = w_pass_cur;
    if (r_state == IDLE && start) w_nxt = w_empty ? DONE : ISSUE;
    if (w_fire) begin
      w_rd_nxt = w_last ? '0 : r_rd_ptr + 1'b1;
      if (w_last) begin
        w_pass_nxt = w_pass_cur - 1'b1;
        if (w_pass_cur == CNT_W'(1)) w_nxt = DRAIN;
      end
    end
    if (r_state == DRAIN && w_pend_nxt == '0) w_nxt = DONE;
    if (r_state == DONE) w_nxt = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rd_ptr <= '0;
      r_pass   <= '0;
      r_pend   <= '0;
      r_len    <= '0;
      r_inst_v <= 1'b0;
      r_inst   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_pass   <= w_pass_nxt;
      r_pend   <= w_pend_nxt;
      r_inst_v <= w_fire;
      if (w_fire) r_inst <= w_cur;
      r_busy   <= w_nxt == ISSUE || w_nxt == DRAIN;
      // drain completion pulses on entry to DONE; an empty start pulses on leaving it
      r_done   <= (r_state == DRAIN && w_nxt == DONE) || (r_state == DONE && !r_done);
      r_err    <= r_err | w_ovf | w_unf | w_ld_err;
      if (r_state == IDLE) r_len <= clr ? '0 : w_ld_ok ? r_len + 1'b1 : r_len;
    end
  end
  always_ff @(posedge clk)
    if (w_ld_ok) r_mem[r_len[PTR_W-1:0]] <= ld_inst;
  assign inst_v   = r_inst_v;
  assign inst     = r_inst;
  assign busy     = r_busy;
  assign done     = r_done;
  assign prog_len = r_len;
  assign err      = r_err;
endmodule
